// File: rtl/countdown_pkg.sv
// Shared state encodings and small elaboration-time helpers for the
// countdown and display stages.
// Contents: 2-bit state localparams, state enum, max/width helper functions.
package countdown_pkg;

  // Alarm FSM encodings. The display stage decodes these, so keep them stable.
  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WARN      = 2'd1;
  localparam logic [1:0] S_ALARM_ON  = 2'd2;
  localparam logic [1:0] S_ALARM_OFF = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = S_IDLE,
    WARN      = S_WARN,
    ALARM_ON  = S_ALARM_ON,
    ALARM_OFF = S_ALARM_OFF
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed for a counter that holds values 0 .. n-1 (never less than 1).
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator for the piezo buzzer.
// Ports: clk, rst (sync, active-high), restart (start a fresh phase, output
//        high next edge), enable (keep toggling), sq (registered square wave).
module tone_gen #(
  parameter int HALF_TONE = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic sq
);

  localparam int            CW   = (HALF_TONE > 2) ? $clog2(HALF_TONE) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF_TONE - 1);

  logic [CW-1:0] cnt_q;
  logic          sq_q;

  // Restart has priority so a new beep always begins with a full high
  // half-period, regardless of where the previous tone phase stood.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else if (restart) begin
      cnt_q <= '0;
      sq_q  <= 1'b1;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        sq_q  <= ~sq_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end
  end

  assign sq = sq_q;

endmodule

// File: rtl/countdown_alarm.sv
// Countdown alarm: short warning chirp on the last three seconds, then a
// beep/gap alarm sequence on expiry that any key press can silence.
// Ports: clk, rst (sync, active-high), seconds[5:0], running, ack_p (in);
//        buzzer, alarm_active, blink (registered out, one cycle after the
//        cycle that caused the change).
module countdown_alarm
  import countdown_pkg::*;
#(
  parameter int CLK_HZ     = 10_000_000,
  parameter int TONE_HZ    = 2000,
  parameter int BEEP_MS    = 200,
  parameter int BEEP_COUNT = 3,
  parameter int WARN_MS    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] seconds,
  input  logic       running,
  input  logic       ack_p,
  output logic       buzzer,
  output logic       alarm_active,
  output logic       blink
);

  // Cycle counts derived at elaboration time only.
  localparam int WARN_CYC  = CLK_HZ / 1000 * WARN_MS;
  localparam int BEEP_CYC  = CLK_HZ / 1000 * BEEP_MS;
  localparam int HALF_TONE = CLK_HZ / (2 * TONE_HZ);

  localparam int DUR_W  = cnt_width(max_int(WARN_CYC, BEEP_CYC));
  localparam int BEEP_W = cnt_width(BEEP_COUNT + 1);

  localparam logic [DUR_W-1:0]  WARN_LAST = DUR_W'(WARN_CYC - 1);
  localparam logic [DUR_W-1:0]  BEEP_LAST = DUR_W'(BEEP_CYC - 1);
  localparam logic [BEEP_W-1:0] BEEP_NUM  = BEEP_W'(BEEP_COUNT);

  state_e            state_q, state_d;
  logic [DUR_W-1:0]  dur_q;
  logic [BEEP_W-1:0] beep_q, beep_d, beep_inc;
  logic [5:0]        sec_prev_q;     // seconds as seen last cycle
  logic              run_prev_q;     // running as seen last cycle
  logic              alarm_active_q;
  logic              blink_q;

  logic expiry;
  logic warn_ev;
  logic enter;        // state (re-)entry this edge: clears the duration counter
  logic tone_restart;
  logic tone_enable;

  // Expiry needs the counter to have been running on the previous cycle, so
  // a decrement while paused, or the first cycle after reset, cannot fire.
  assign expiry  = (seconds == 6'd0) && (sec_prev_q != 6'd0) && run_prev_q;
  assign warn_ev = running && (seconds != sec_prev_q) &&
                   ((seconds == 6'd3) || (seconds == 6'd2) || (seconds == 6'd1));

  assign beep_inc = beep_q + 1'b1;

  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    enter   = 1'b0;
    // Expiry beats everything, including a simultaneous ack_p, and restarts
    // an alarm already in progress from its first beep.
    if (expiry) begin
      state_d = ALARM_ON;
      beep_d  = '0;
      enter   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (warn_ev) begin
            state_d = WARN;
            enter   = 1'b1;
          end
        end
        WARN: begin
          // ack_p deliberately has no effect on the warning chirp.
          if (dur_q == WARN_LAST) begin
            state_d = IDLE;
            enter   = 1'b1;
          end
        end
        ALARM_ON: begin
          if (ack_p) begin
            state_d = IDLE;
            beep_d  = '0;
            enter   = 1'b1;
          end else if (dur_q == BEEP_LAST) begin
            state_d = ALARM_OFF;
            enter   = 1'b1;
          end
        end
        ALARM_OFF: begin
          if (ack_p) begin
            state_d = IDLE;
            beep_d  = '0;
            enter   = 1'b1;
          end else if (dur_q == BEEP_LAST) begin
            // A beep counts as complete once its gap has elapsed.
            enter = 1'b1;
            if (beep_inc < BEEP_NUM) begin
              state_d = ALARM_ON;
              beep_d  = beep_inc;
            end else begin
              state_d = IDLE;
              beep_d  = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          beep_d  = '0;
          enter   = 1'b1;
        end
      endcase
    end
  end

  // The tone is driven from the next state so the buzzer lines up with the
  // registered state: high on the very edge that enters WARN/ALARM_ON.
  assign tone_enable  = (state_d == WARN) || (state_d == ALARM_ON);
  assign tone_restart = enter && tone_enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      dur_q          <= '0;
      beep_q         <= '0;
      sec_prev_q     <= 6'd0;
      run_prev_q     <= 1'b0;
      alarm_active_q <= 1'b0;
      blink_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      beep_q     <= beep_d;
      sec_prev_q <= seconds;
      run_prev_q <= running;
      if (enter || (state_d == IDLE)) begin
        dur_q <= '0;
      end else begin
        dur_q <= dur_q + 1'b1;
      end
      alarm_active_q <= (state_d == ALARM_ON) || (state_d == ALARM_OFF);
      blink_q        <= (state_d == ALARM_OFF);
    end
  end

  tone_gen #(
    .HALF_TONE (HALF_TONE)
  ) u_tone (
    .clk     (clk),
    .rst     (rst),
    .restart (tone_restart),
    .enable  (tone_enable),
    .sq      (buzzer)
  );

  assign alarm_active = alarm_active_q;
  assign blink        = blink_q;

endmodule

// File: tb/tb_countdown_alarm.sv
module tb_countdown_alarm;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] seconds;
  logic       running;
  logic       ack_p;
  logic       buzzer;
  logic       alarm_active;
  logic       blink;

  always #5 clk = ~clk;

  countdown_alarm #(
    .CLK_HZ     (10000),
    .TONE_HZ    (1000),
    .BEEP_MS    (2),
    .BEEP_COUNT (3),
    .WARN_MS    (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .seconds      (seconds),
    .running      (running),
    .ack_p        (ack_p),
    .buzzer       (buzzer),
    .alarm_active (alarm_active),
    .blink        (blink)
  );

  // Expected {buzzer, alarm_active, blink} after the edge that samples
  // each driven input vector.
  logic [2:0] exp_q[$];
  string      name_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;

  task automatic step(input logic r, input logic [5:0] s, input logic run,
                      input logic a, input logic [2:0] e, input string nm);
    @(negedge clk);
    rst     = r;
    seconds = s;
    running = run;
    ack_p   = a;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Alarm cycle j (0 = first ALARM_ON cycle): 20 cycles tone (5 high,
  // 5 low, ...), then 20 cycles silent gap with blink.
  function automatic logic [2:0] alarm_exp(input int j);
    int p;
    p = j % 40;
    if (p < 20) return {((p / 5) % 2 == 0), 1'b1, 1'b0};
    return 3'b011;
  endfunction

  task automatic alarm_run(input int j0, input int n, input string nm);
    for (int j = j0; j < j0 + n; j++) step(1'b0, 6'd0, 1'b1, 1'b0, alarm_exp(j), nm);
  endtask

  // Arm an expiry: seconds=1 while paused (no warning), then running.
  task automatic arm();
    step(1'b0, 6'd1, 1'b0, 1'b0, 3'b000, "arm_paused");
    step(1'b0, 6'd1, 1'b1, 1'b0, 3'b000, "arm_running");
  endtask

  // Monitor: one expected vector per clock, checked just after the edge.
  initial begin : monitor
    logic [2:0] e;
    logic [2:0] got;
    string      nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        got = {buzzer, alarm_active, blink};
        n_tests++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: buzzer/alarm_active/blink got %b required %b at %0t",
                   nm, got, e, $time);
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; seconds = 6'd0; running = 1'b0; ack_p = 1'b0;

    // Reset and release: first cycle after release cannot expire.
    step(1'b1, 6'd0, 1'b0, 1'b0, 3'b000, "reset");
    step(1'b1, 6'd0, 1'b0, 1'b0, 3'b000, "reset");
    step(1'b0, 6'd5, 1'b0, 1'b0, 3'b000, "post_reset");

    // Warning chirp on 4->3; ack_p inside WARN is ignored.
    step(1'b0, 6'd5, 1'b1, 1'b0, 3'b000, "warn_pre");
    step(1'b0, 6'd4, 1'b1, 1'b0, 3'b000, "warn_pre");
    for (int k = 0; k < 10; k++)
      step(1'b0, 6'd3, 1'b1, (k == 2), {(k < 5), 2'b00}, "warn");
    for (int k = 0; k < 3; k++) step(1'b0, 6'd3, 1'b1, 1'b0, 3'b000, "warn_end");

    // Reaching 0 while paused is not an expiry.
    step(1'b0, 6'd1, 1'b0, 1'b0, 3'b000, "paused");
    for (int k = 0; k < 4; k++) step(1'b0, 6'd0, 1'b0, 1'b0, 3'b000, "paused");

    // Full alarm: 3 beeps + 3 gaps, then back to idle.
    arm();
    alarm_run(0, 120, "alarm");
    for (int k = 0; k < 3; k++) step(1'b0, 6'd0, 1'b1, 1'b0, 3'b000, "alarm_done");

    // ack_p in the second gap silences immediately; ack_p in IDLE does nothing.
    arm();
    alarm_run(0, 65, "ack_seq");
    step(1'b0, 6'd0, 1'b1, 1'b1, 3'b000, "ack_off2");
    step(1'b0, 6'd0, 1'b1, 1'b0, 3'b000, "ack_idle");
    step(1'b0, 6'd0, 1'b1, 1'b1, 3'b000, "ack_idle_ign");

    // Expiry and ack_p together: the alarm starts.
    arm();
    step(1'b0, 6'd0, 1'b1, 1'b1, 3'b110, "exp_ack");
    alarm_run(1, 4, "exp_ack_run");
    step(1'b0, 6'd0, 1'b1, 1'b1, 3'b000, "ack_on");

    // Reset mid-beep, then seconds held at 0 must not alarm.
    arm();
    alarm_run(0, 7, "pre_rst");
    step(1'b1, 6'd0, 1'b1, 1'b0, 3'b000, "rst_mid");
    for (int k = 0; k < 5; k++) step(1'b0, 6'd0, 1'b1, 1'b0, 3'b000, "rst_hold0");

    // Expiry 4 cycles into WARN: alarm starts with a fresh tone phase.
    for (int k = 0; k < 4; k++) step(1'b0, 6'd1, 1'b1, 1'b0, 3'b100, "warn1");
    step(1'b0, 6'd0, 1'b1, 1'b0, 3'b110, "warn_exp");
    alarm_run(1, 10, "warn_exp_run");
    step(1'b0, 6'd0, 1'b1, 1'b1, 3'b000, "end_ack");
    step(1'b0, 6'd0, 1'b1, 1'b0, 3'b000, "end_idle");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #3;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
